// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: Tnew/Tuse encodings,
// the exception vector, the MDU sequencer state type and the RAW hazard rule.
package pipe_hazard_ctrl_pkg;

  // Tnew/Tuse are 2-bit cycle counts. A Tuse of 3 marks an operand that the
  // instruction never reads. No Tnew can exceed 3, so that operand never stalls.
  localparam logic [1:0] T_0      = 2'd0;
  localparam logic [1:0] T_1      = 2'd1;
  localparam logic [1:0] T_2      = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Redirect target that every stage register loads when req is asserted
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A D-stage source operand must wait if a younger-producing stage writes it
  // and that result arrives later than the operand is needed. Register 0 is
  // hard-wired to zero, so it never creates a dependency.
  function automatic logic raw_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_dst,
    input logic [1:0] e_tnew,
    input logic [4:0] m_dst,
    input logic [1:0] m_tnew
  );
    logic from_e;
    logic from_m;
    from_e = (src == e_dst) && (e_tnew > tuse);
    from_m = (src == m_dst) && (m_tnew > tuse);
    return (src != 5'd0) && (from_e || from_m);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_seq.sv
// Multiply/divide busy sequencer. An accepted start loads a down-counter with
// the op latency, and busy stays high until that count has expired. Once an op
// has started it cannot be aborted.
module md_busy_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  input  logic kill,
  output logic busy
);

  md_state_e          state;
  md_state_e          state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  // State and counter registers; synchronous reset wins over everything
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: accept a start only when idle and not killed, then count down
  always_comb begin
    // NOTE: hold-current defaults first, so no path leaves a signal unassigned
    // and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      MD_IDLE: begin
        if (start && !kill) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      MD_BUSY: begin
        // A start seen here can only be stray; the D stall keeps it from happening
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = MD_IDLE;
        end
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: RAW and MDU stalls, delay-slot nullify,
// exception redirect, and a count of the cycles in which D was stalled.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic        d_nullify,
  input  logic [4:0]  e_dst,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_dst,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_div,
  input  logic        m_exc,
  output logic        stall_f,
  output logic        stall_d,
  output logic        clear_d,
  output logic        clear_e,
  output logic        req,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  logic hazard_rs;
  logic hazard_rt;
  logic md_start_acc;
  logic md_stall;
  logic stall;

  md_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_seq (
    .clk   (clk),
    .reset (reset),
    .start (e_md_start),
    .div   (e_md_div),
    .kill  (m_exc),
    .busy  (md_busy)
  );

  assign hazard_rs = raw_hazard(d_rs, d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
  assign hazard_rt = raw_hazard(d_rt, d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew);

  // A start in E is accepted unless an exception at M flushes it in the same cycle
  assign md_start_acc = e_md_start && !m_exc;
  assign md_stall     = d_is_md && (md_busy || md_start_acc);
  assign stall        = hazard_rs || hazard_rt || md_stall;

  // Stage-register controls in priority order: exception, stall, nullify
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    clear_d = 1'b0;
    clear_e = 1'b0;
    req     = 1'b0;
    if (m_exc) begin
      req = 1'b1;
    end else if (stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      clear_e = 1'b1;
    end else if (d_nullify) begin
      clear_d = 1'b1;
    end
  end

  // Performance counter of stalled D cycles; wraps naturally, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall_d) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors with literal expectations plus
// a cycle-level reference model checked on every falling edge.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic        d_is_md;
  logic        d_nullify;
  logic [4:0]  e_dst;
  logic [1:0]  e_tnew;
  logic [4:0]  m_dst;
  logic [1:0]  m_tnew;
  logic        e_md_start;
  logic        e_md_div;
  logic        m_exc;
  logic        stall_f;
  logic        stall_d;
  logic        clear_d;
  logic        clear_e;
  logic        req;
  logic        md_busy;
  logic [31:0] stall_cycles;

  int tests;
  int fails;

  pipe_hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_tuse_rs    (d_tuse_rs),
    .d_tuse_rt    (d_tuse_rt),
    .d_is_md      (d_is_md),
    .d_nullify    (d_nullify),
    .e_dst        (e_dst),
    .e_tnew       (e_tnew),
    .m_dst        (m_dst),
    .m_tnew       (m_tnew),
    .e_md_start   (e_md_start),
    .e_md_div     (e_md_div),
    .m_exc        (m_exc),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .clear_d      (clear_d),
    .clear_e      (clear_e),
    .req          (req),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The MDU is modelled as "cycles of busy remaining" and the stall counter
  // as a plain integer tally.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic clear_d;
    logic clear_e;
    logic req;
    logic md_busy;
  } exp_t;

  int          m_busy_left;
  logic [31:0] m_cnt;
  logic        mdl_valid = 1'b0;
  exp_t        exp_now;

  function automatic logic needs_wait(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] ed, input logic [1:0] et,
                                      input logic [4:0] md, input logic [1:0] mt);
    if (src == 5'd0) return 1'b0;
    if (src == ed && int'(et) > int'(tuse)) return 1'b1;
    if (src == md && int'(mt) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model_out(input int busy_left);
    exp_t o;
    logic busy;
    logic stl;
    o    = '0;
    busy = (busy_left > 0);
    stl  = needs_wait(d_rs, d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew)
        || needs_wait(d_rt, d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew)
        || (d_is_md && (busy || (e_md_start && !m_exc)));
    o.md_busy = busy;
    if (m_exc) o.req = 1'b1;
    else if (stl) begin
      o.stall_f = 1'b1;
      o.stall_d = 1'b1;
      o.clear_e = 1'b1;
    end else if (d_nullify) o.clear_d = 1'b1;
    return o;
  endfunction

  assign exp_now = model_out(m_busy_left);

  always @(posedge clk) begin
    if (reset) begin
      m_busy_left <= 0;
      m_cnt       <= '0;
      mdl_valid   <= 1'b1;
    end else begin
      if (exp_now.stall_d) m_cnt <= m_cnt + 32'd1;
      if (m_busy_left > 0) m_busy_left <= m_busy_left - 1;
      else if (e_md_start && !m_exc) m_busy_left <= e_md_div ? 10 : 5;
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    if (mdl_valid) begin
      check("mdl_stall_f",      {31'd0, stall_f}, {31'd0, exp_now.stall_f});
      check("mdl_stall_d",      {31'd0, stall_d}, {31'd0, exp_now.stall_d});
      check("mdl_clear_d",      {31'd0, clear_d}, {31'd0, exp_now.clear_d});
      check("mdl_clear_e",      {31'd0, clear_e}, {31'd0, exp_now.clear_e});
      check("mdl_req",          {31'd0, req},     {31'd0, exp_now.req});
      check("mdl_md_busy",      {31'd0, md_busy}, {31'd0, exp_now.md_busy});
      check("mdl_stall_cycles", stall_cycles,     m_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_inputs();
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_is_md = 1'b0; d_nullify = 1'b0;
    e_dst = 5'd0; e_tnew = 2'd0; m_dst = 5'd0; m_tnew = 2'd0;
    e_md_start = 1'b0; e_md_div = 1'b0; m_exc = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_n;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    idle_inputs();
    next();
    #1;
    check("rst_md_busy", {31'd0, md_busy}, 32'd0);
    check("rst_stall_cycles", stall_cycles, 32'd0);
    check("rst_stall_d", {31'd0, stall_d}, 32'd0);
    check("rst_req", {31'd0, req}, 32'd0);
    reset = 1'b0;

    // RAW: load in E, consumer needs rs right away
    next();
    d_rs = 5'd8; d_tuse_rs = 2'd0; e_dst = 5'd8; e_tnew = 2'd2;
    #1;
    check("raw_e_stall_f", {31'd0, stall_f}, 32'd1);
    check("raw_e_stall_d", {31'd0, stall_d}, 32'd1);
    check("raw_e_clear_e", {31'd0, clear_e}, 32'd1);
    check("raw_e_clear_d", {31'd0, clear_d}, 32'd0);
    // Value moved to M with Tnew 1, consumer now needs it in 1
    next();
    e_dst = 5'd0; e_tnew = 2'd0; m_dst = 5'd8; m_tnew = 2'd1; d_tuse_rs = 2'd1;
    #1;
    check("raw_m_resolved", {31'd0, stall_d}, 32'd0);
    // Register 0 never hazards
    next();
    idle_inputs();
    d_rs = 5'd0; d_tuse_rs = 2'd0; e_dst = 5'd0; e_tnew = 2'd2;
    #1;
    check("raw_r0_no_stall", {31'd0, stall_d}, 32'd0);
    // rt hazard from M
    next();
    idle_inputs();
    d_rt = 5'd5; d_tuse_rt = 2'd1; m_dst = 5'd5; m_tnew = 2'd2;
    #1;
    check("raw_rt_m_stall", {31'd0, stall_d}, 32'd1);
    // Tnew equal to Tuse is in time
    next();
    d_tuse_rt = 2'd2;
    #1;
    check("raw_rt_equal_ok", {31'd0, stall_d}, 32'd0);
    // Tuse 3 marks an unused operand
    next();
    idle_inputs();
    d_rt = 5'd5; d_tuse_rt = 2'd3; e_dst = 5'd5; e_tnew = 2'd3;
    #1;
    check("raw_unused_ok", {31'd0, stall_d}, 32'd0);

    // Mult busy window: start cycle + 5 busy cycles all stall an md instr
    next();
    idle_inputs();
    #1;
    check("pre_mult_count", stall_cycles, 32'd2);
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_div = 1'b0;
    #1;
    check("mult_start_stall", {31'd0, stall_d}, 32'd1);
    check("mult_start_busy", {31'd0, md_busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      next();
      e_md_start = 1'b0;
      #1;
      check("mult_busy", {31'd0, md_busy}, 32'd1);
      check("mult_stall", {31'd0, stall_d}, 32'd1);
    end
    next();
    #1;
    check("mult_done_busy", {31'd0, md_busy}, 32'd0);
    check("mult_done_stall", {31'd0, stall_d}, 32'd0);
    check("mult_count", stall_cycles, 32'd8);

    // Div busy window: busy for exactly 10 cycles, non-md instr never stalls
    idle_inputs();
    e_md_start = 1'b1; e_md_div = 1'b1;
    #1;
    check("div_start_stall", {31'd0, stall_d}, 32'd0);
    busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      next();
      e_md_start = 1'b0;
      #1;
      if (md_busy) busy_n++;
      check("div_nonmd_stall", {31'd0, stall_d}, 32'd0);
    end
    check("div_busy_len", busy_n, 32'd10);

    // Exception wins over hazard and blocks the mult/div start
    idle_inputs();
    d_rs = 5'd8; d_tuse_rs = 2'd0; e_dst = 5'd8; e_tnew = 2'd2;
    d_is_md = 1'b1; e_md_start = 1'b1; m_exc = 1'b1;
    #1;
    check("exc_req", {31'd0, req}, 32'd1);
    check("exc_stall_d", {31'd0, stall_d}, 32'd0);
    check("exc_stall_f", {31'd0, stall_f}, 32'd0);
    check("exc_clear_e", {31'd0, clear_e}, 32'd0);
    next();
    idle_inputs();
    #1;
    check("exc_blocked_start", {31'd0, md_busy}, 32'd0);
    check("exc_req_gone", {31'd0, req}, 32'd0);

    // Exception during BUSY does not abort the op
    e_md_start = 1'b1;
    next();
    e_md_start = 1'b0;
    #1;
    check("excb_busy1", {31'd0, md_busy}, 32'd1);
    next();
    m_exc = 1'b1;
    #1;
    check("excb_req", {31'd0, req}, 32'd1);
    check("excb_busy2", {31'd0, md_busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      next();
      m_exc = 1'b0;
      #1;
      check("excb_busy_tail", {31'd0, md_busy}, 32'd1);
    end
    next();
    #1;
    check("excb_done", {31'd0, md_busy}, 32'd0);

    // Nullify alone, then nullify under a hazard (stall wins)
    d_nullify = 1'b1;
    #1;
    check("null_clear_d", {31'd0, clear_d}, 32'd1);
    check("null_stall_d", {31'd0, stall_d}, 32'd0);
    check("null_clear_e", {31'd0, clear_e}, 32'd0);
    next();
    d_rs = 5'd8; d_tuse_rs = 2'd0; e_dst = 5'd8; e_tnew = 2'd2;
    #1;
    check("null_hz_clear_d", {31'd0, clear_d}, 32'd0);
    check("null_hz_stall_d", {31'd0, stall_d}, 32'd1);

    // Reset in the middle of a div
    next();
    idle_inputs();
    e_md_start = 1'b1; e_md_div = 1'b1;
    next();
    e_md_start = 1'b0;
    next();
    next();
    #1;
    check("rstmid_busy_before", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    next();
    #1;
    check("rstmid_busy", {31'd0, md_busy}, 32'd0);
    check("rstmid_count", stall_cycles, 32'd0);
    reset = 1'b0;
    next();
    #1;
    check("rstmid_busy_after", {31'd0, md_busy}, 32'd0);
    next();
    next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline registers (F/D/E/M/W).
- Computes the stall, bubble, nullify and exception-redirect controls that every stage register consumes.
- Resolves RAW hazards using Tuse/Tnew.
- Owns the multi-cycle mult/div busy sequencer.
- Keeps a stall-cycle performance counter.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start
DIV_CYCLES, 10, busy cycles after a div/divu start
CNT_W, 4, width of the MDU busy down-counter (must hold DIV_CYCLES)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
d_rs  in  5  D-stage rs register index
d_rt  in  5  D-stage rt register index
d_tuse_rs  in  2  cycles until D needs rs (3 = unused)
d_tuse_rt  in  2  cycles until D needs rt (3 = unused)
d_is_md  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
d_nullify  in  1  D-stage branch-likely not taken; nullify delay slot
e_dst  in  5  E-stage destination register (0 = none)
e_tnew  in  2  cycles until E result is available
m_dst  in  5  M-stage destination register
m_tnew  in  2  cycles until M result is available
e_md_start  in  1  E instr starts mult/div this cycle
e_md_div  in  1  1 = started op is div/divu, 0 = mult/multu
m_exc  in  1  exception/interrupt taken at M
stall_f  out  1  hold PC/F register
stall_d  out  1  hold D register
clear_d  out  1  nullify D register (instr to 0, PC to PC+4)
clear_e  out  1  insert bubble into E register
req  out  1  exception redirect to all stage registers (PC to 0x0000_4180)
md_busy  out  1  mult/div unit busy
stall_cycles  out  32  count of cycles with stall_d asserted

Behaviour:
Reset values:
- All control outputs are 0.
- MDU state is IDLE with counter 0.
- stall_cycles is 0.

Data-hazard stall (combinational):
- A rs hazard exists if d_rs != 0 and either:
  - d_rs == e_dst and e_tnew > d_tuse_rs, or
  - d_rs == m_dst and m_tnew > d_tuse_rs.
- The rt hazard is the same condition using d_rt and d_tuse_rt.

MDU stall (combinational):
- Asserted when d_is_md && (md_busy || e_md_start_acc).
- e_md_start_acc = e_md_start && !m_exc.

Output priority, highest first:
1. m_exc: req=1, all other controls 0.
2. stall = data hazard or MDU stall: stall_f=1, stall_d=1, clear_e=1, clear_d=0.
3. d_nullify: clear_d=1.
4. Otherwise all controls 0.

MDU FSM, states IDLE and BUSY:
- IDLE to BUSY on e_md_start_acc. The counter loads DIV_CYCLES if e_md_div, else MULT_CYCLES.
- In BUSY the counter decrements every cycle.
- BUSY to IDLE when the counter reaches 1 at a clock edge, so it reads 0 afterwards.
- md_busy = (state == BUSY).
- An e_md_start_acc while already BUSY cannot occur, because the D stall prevents it. It is ignored anyway.
- m_exc while BUSY does not abort: the op was already committed and runs to completion.
- m_exc in the same cycle as e_md_start blocks the start; the FSM stays IDLE.

Stall counter:
- stall_cycles increments by 1 on each clock where stall_d is 1.
- It wraps from 0xFFFF_FFFF to 0.
- It is cleared only by reset.

Reset mid-operation:
- reset has priority over everything.
- A reset while BUSY returns the FSM to IDLE and the counter to 0 on that edge.

Decomposition:
- Shared package holds:
  - TNEW/TUSE encoding constants (0..3, 3 = unused).
  - EXC_VECTOR = 32'h0000_4180.
  - The MDU state enum.
- One natural sub-module, md_busy_seq: the FSM and down-counter, with inputs start/div/kill and output busy.
- Hazard and priority logic stay in the top level.

Test Plan:
- RAW with lw then use: d_rs=8, d_tuse_rs=0, e_dst=8, e_tnew=2 -> stall_f=stall_d=clear_e=1 for 1 cycle, then 0 once the value moves to M with m_tnew=1 and d_tuse_rs=1. Repeat with d_rs=0 -> no stall.
- Mult busy window: pulse e_md_start with e_md_div=0, hold d_is_md=1 -> stall_d=1 in the start cycle plus the 5 following cycles, then 0; stall_cycles advances by 6.
- Div busy window: pulse e_md_start with e_md_div=1 -> md_busy=1 for exactly 10 cycles. A non-md D instruction is never stalled during that window.
- Exception priority: m_exc=1 together with a hazard and e_md_start -> req=1, stall_d=clear_e=0, md_busy stays 0 on the next cycle.
- Exception during BUSY: start mult, assert m_exc on the 2nd busy cycle -> req=1 that cycle, md_busy remains 1 until the original 5-cycle count expires.
- Nullify and reset: d_nullify=1 with no hazard -> clear_d=1. Assert reset mid-div -> md_busy=0 and stall_cycles=0 next cycle.
